// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store sequencer between execute and Memory_Interface
module load_store_unit #(
  parameter int LATENCY       = 2,
  parameter int MEM_ADDR_BITS = 15,
  parameter int TAG_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_base,
  input  logic [31:0]      req_offset,
  input  logic [31:0]      req_store_data,
  input  logic [TAG_W-1:0] req_rd,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_rd,
  output logic             resp_is_load,
  output logic             resp_exception,
  output logic [3:0]       resp_cause,
  output logic [31:0]      resp_addr,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data_in,
  input  logic [31:0]      mem_data_out,
  output logic             mem_enable,
  output logic             mem_write_en,
  output logic [1:0]       mem_size_select,
  output logic             mem_extension_mode
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;

  logic [31:0] ea;
  logic        f3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic [3:0]  req_cause;
  logic        req_fault;

  assign ea = req_base + req_offset;

  // Fault classification in trap priority order: illegal, misaligned, out of range.
  always_comb begin
    f3_legal     = 1'b0;
    misaligned   = 1'b0;
    out_of_range = |ea[31:MEM_ADDR_BITS];
    req_cause    = 4'd0;
    if (req_is_store) begin
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    case (req_funct3[1:0])
      2'b01:   misaligned = ea[0];
      2'b10:   misaligned = |ea[1:0];
      default: misaligned = 1'b0;
    endcase
    if (!f3_legal) begin
      req_cause = 4'd2;
    end else if (misaligned) begin
      req_cause = req_is_store ? 4'd6 : 4'd4;
    end else if (out_of_range) begin
      req_cause = req_is_store ? 4'd7 : 4'd5;
    end
    req_fault = (req_cause != 4'd0);
  end

  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_enable   = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault) begin
            state_next = RESP;
          end else if (req_is_store) begin
            state_next = STORE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      STORE: begin
        mem_enable   = 1'b1;
        mem_write_en = 1'b1;
        state_next   = RESP;
      end
      LOAD: begin
        mem_enable = 1'b1;
        if (cnt == CNT_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory controls only move on a non-faulting accept, so they hold through IDLE/RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt                <= '0;
      resp_data          <= '0;
      resp_rd            <= '0;
      resp_is_load       <= 1'b0;
      resp_exception     <= 1'b0;
      resp_cause         <= 4'd0;
      resp_addr          <= '0;
      mem_address        <= '0;
      mem_data_in        <= '0;
      mem_size_select    <= 2'd0;
      mem_extension_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt            <= '0;
            resp_data      <= '0;
            resp_rd        <= req_rd;
            resp_is_load   <= !req_is_store;
            resp_exception <= req_fault;
            resp_cause     <= req_cause;
            resp_addr      <= ea;
            if (!req_fault) begin
              mem_address        <= ea;
              mem_data_in        <= req_store_data;
              mem_size_select    <= req_funct3[1:0];
              mem_extension_mode <= req_funct3[2];
            end
          end
        end
        LOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            resp_data <= mem_data_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
